// File: rtl/spi_reg_bank.sv
// SPI mode-0 target holding the five PWM control registers.
// SPI pins are oversampled by clk; writes land on the ncs rise that closes a frame.
//
// state  | meaning
// IDLE   | waiting for an armed ncs fall
// SHIFT  | frame active, shifting copi on sclk rises, driving cipo on falls
// COMMIT | one cycle: apply a valid write, then back to IDLE
module spi_reg_bank #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [6:0] MAX_ADDR    = 7'h04
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       ncs,
   input  logic       copi,
   output logic       cipo,
   output logic       cipo_oe,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sclk_sync, ncs_sync, copi_sync, vld_sync;
   logic                   sclk_s, ncs_s, copi_s, sync_vld;
   logic                   sclk_d, ncs_d;
   logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall;
   logic                   armed;

   logic [15:0] shift_q;
   logic [15:0] shift_nxt;
   logic [4:0]  bit_cnt;
   logic        overrun;
   logic [7:0]  tx_q;
   logic        cipo_q;
   logic [7:0]  regs [5];
   logic [7:0]  rd_data;
   logic        commit_ok;

   // vld_sync fills with ones after reset so that arming only trusts real pin samples,
   // not the reset values still sitting in the ncs synchronizer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         ncs_sync  <= '1;
         copi_sync <= '0;
         vld_sync  <= '0;
         sclk_d    <= 1'b0;
         ncs_d     <= 1'b1;
         armed     <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
         copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
         vld_sync  <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
         sclk_d    <= sclk_s;
         ncs_d     <= ncs_s;
         if (sync_vld && ncs_s)
            armed <= 1'b1;
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign ncs_s     = ncs_sync[SYNC_STAGES-1];
   assign copi_s    = copi_sync[SYNC_STAGES-1];
   assign sync_vld  = vld_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign ncs_rise  = ncs_s & ~ncs_d;
   assign ncs_fall  = ~ncs_s & ncs_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ncs_fall && armed) state_d = SHIFT;
         SHIFT:   if (ncs_rise) state_d = COMMIT;
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign shift_nxt = {shift_q[14:0], copi_s};

   // Read mux addressed by the address bits as they stand after the 8th sclk rise.
   always_comb begin
      rd_data = 8'h00;
      if (shift_nxt[6:0] <= MAX_ADDR) begin
         for (int i = 0; i < 5; i++)
            if (shift_nxt[6:0] == 7'(i)) rd_data = regs[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         bit_cnt <= '0;
         overrun <= 1'b0;
         tx_q    <= '0;
         cipo_q  <= 1'b0;
      end else if (state_q == IDLE && state_d == SHIFT) begin
         shift_q <= '0;
         bit_cnt <= '0;
         overrun <= 1'b0;
         tx_q    <= '0;
         cipo_q  <= 1'b0;
      end else if (state_q == SHIFT) begin
         if (sclk_rise) begin
            if (bit_cnt == 5'd16) begin
               overrun <= 1'b1;
            end else begin
               shift_q <= shift_nxt;
               bit_cnt <= bit_cnt + 5'd1;
               if (bit_cnt == 5'd7 && !shift_nxt[7])
                  tx_q <= rd_data;
            end
         end
         if (sclk_fall && bit_cnt >= 5'd8 && bit_cnt <= 5'd15) begin
            cipo_q <= tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b0};
         end
      end
   end

   assign commit_ok = (bit_cnt == 5'd16) && !overrun && shift_q[15] &&
                      (shift_q[14:8] <= MAX_ADDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 5; i++) regs[i] <= 8'h00;
      end else if (state_q == COMMIT && commit_ok) begin
         for (int i = 0; i < 5; i++)
            if (shift_q[14:8] == 7'(i)) regs[i] <= shift_q[7:0];
      end
   end

   assign cipo            = (state_q == SHIFT) & cipo_q;
   assign cipo_oe         = (state_q == SHIFT);
   assign en_reg_out_7_0  = regs[0];
   assign en_reg_out_15_8 = regs[1];
   assign en_reg_pwm_7_0  = regs[2];
   assign en_reg_pwm_15_8 = regs[3];
   assign pwm_duty_cycle  = regs[4];

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: writes, discarded frames, readback and mid-frame reset.
module tb_spi_reg_bank;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0;
   logic       ncs = 1'b1;
   logic       copi = 1'b0;
   logic       cipo, cipo_oe;
   logic [7:0] r0, r1, r2, r3, r4;
   logic [7:0] rx_byte;
   int         checks = 0;
   int         errors = 0;

   spi_reg_bank #(.SYNC_STAGES(2), .MAX_ADDR(7'h04)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .sclk            (sclk),
      .ncs             (ncs),
      .copi            (copi),
      .cipo            (cipo),
      .cipo_oe         (cipo_oe),
      .en_reg_out_7_0  (r0),
      .en_reg_out_15_8 (r1),
      .en_reg_pwm_7_0  (r2),
      .en_reg_pwm_15_8 (r3),
      .pwm_duty_cycle  (r4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
      chk({tag, ".r0"}, r0, e0);
      chk({tag, ".r1"}, r1, e1);
      chk({tag, ".r2"}, r2, e2);
      chk({tag, ".r3"}, r3, e3);
      chk({tag, ".r4"}, r4, e4);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_low();
      @(negedge clk);
      ncs = 1'b0;
      wait_clk(6);
   endtask

   task automatic cs_high();
      @(negedge clk);
      ncs = 1'b1;
      wait_clk(10);
   endtask

   // Bits first..last of w, MSB first; indices beyond 15 send 0. cipo is
   // captured into rx_byte just before rises 8..15.
   task automatic spi_bits(input logic [15:0] w, input int first, input int last);
      for (int j = first; j <= last; j++) begin
         copi = (j < 16) ? w[15-j] : 1'b0;
         wait_clk(3);
         if (j >= 8 && j <= 15) rx_byte = {rx_byte[6:0], cipo};
         sclk = 1'b1;
         wait_clk(6);
         sclk = 1'b0;
         wait_clk(3);
      end
   endtask

   task automatic frame(input logic [15:0] w, input int nbits);
      cs_low();
      spi_bits(w, 0, nbits - 1);
      cs_high();
   endtask

   initial begin
      wait_clk(3);
      chk_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      chk("reset.cipo", {7'd0, cipo}, 8'h00);
      chk("reset.cipo_oe", {7'd0, cipo_oe}, 8'h00);
      rst_n = 1'b1;
      wait_clk(6);

      // Write 0x80FF and pin the commit latency at SYNC_STAGES+2 = 4 clocks.
      cs_low();
      spi_bits(16'h80FF, 0, 15);
      chk("oe_in_frame", {7'd0, cipo_oe}, 8'h01);
      @(negedge clk);
      ncs = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("latency.before", r0, 8'h00);
      @(posedge clk);
      #1 chk("latency.at", r0, 8'hFF);
      wait_clk(10);
      chk_regs("wr0", 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
      chk("oe_after_frame", {7'd0, cipo_oe}, 8'h00);

      frame(16'h84A5, 16);
      chk_regs("wr_duty", 8'hFF, 8'h00, 8'h00, 8'h00, 8'hA5);
      frame(16'h8533, 16);
      chk_regs("bad_addr", 8'hFF, 8'h00, 8'h00, 8'h00, 8'hA5);

      frame(16'h8211, 15);
      chk("short15", r2, 8'h00);
      frame(16'h8211, 17);
      chk("long17", r2, 8'h00);
      frame(16'h8211, 16);
      chk_regs("wr_pwm0", 8'hFF, 8'h00, 8'h11, 8'h00, 8'hA5);

      frame(16'h833C, 16);
      chk("wr_pwm1", r3, 8'h3C);
      rx_byte = 8'h00;
      cs_low();
      spi_bits(16'h0300, 0, 15);
      chk("read.oe_low_cs", {7'd0, cipo_oe}, 8'h01);
      cs_high();
      chk("read.data", rx_byte, 8'h3C);
      chk("read.oe_high_cs", {7'd0, cipo_oe}, 8'h00);
      chk("read.cipo_idle", {7'd0, cipo}, 8'h00);
      chk_regs("read.noeffect", 8'hFF, 8'h00, 8'h11, 8'h3C, 8'hA5);
      rx_byte = 8'hFF;
      frame(16'h7F00, 16);
      chk("read.bad_addr", rx_byte, 8'h00);

      // Reset after 10 bits, release with ncs still low, finish the frame.
      cs_low();
      spi_bits(16'h81C3, 0, 9);
      rst_n = 1'b0;
      #1;
      chk_regs("midrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      chk("midrst.cipo", {7'd0, cipo}, 8'h00);
      chk("midrst.cipo_oe", {7'd0, cipo_oe}, 8'h00);
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(3);
      spi_bits(16'h81C3, 10, 15);
      cs_high();
      chk_regs("midrst.tail", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      frame(16'h81C3, 16);
      chk_regs("after_rst", 8'h00, 8'hC3, 8'h00, 8'h00, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
